// File: rtl/stackcalc_exec.sv
// Stack calculator execute stage: edge-triggered LIFO of 4-bit values with sticky error and carry.
// Define STACKCALC_SYNC_EN for a two-flop strobe/instruction synchronizer (3-edge latency, else 2).
module stackcalc_exec #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] cmd,
    output logic [7:0] out
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SPW = $clog2(DEPTH + 1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
    localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
    localparam logic [SPW-1:0] SP_TWO  = SPW'(2);

    typedef enum logic [2:0] {
        OP_NOP, OP_POP, OP_ADD, OP_SUB, OP_DUP, OP_SWAP, OP_NOT, OP_CLR
    } op_e;

    function automatic logic [4:0] add_c(input logic [3:0] a, input logic [3:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [4:0] sub_b(input logic [3:0] a, input logic [3:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    logic       strb_sync;
    logic [4:0] ins_sync;
    logic       prev_q, prev_d;

    // Strobe bits reset high so a strobe held through reset never looks like a rising edge.
`ifdef STACKCALC_SYNC_EN
    logic       strb_s1_q, strb_s1_d, strb_s2_q, strb_s2_d;
    logic [4:0] ins_s1_q, ins_s1_d, ins_s2_q, ins_s2_d;

    always_comb begin
        strb_s1_d = cmd[5];
        strb_s2_d = strb_s1_q;
        ins_s1_d  = cmd[4:0];
        ins_s2_d  = ins_s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            strb_s1_q <= 1'b1;
            strb_s2_q <= 1'b1;
        end else begin
            strb_s1_q <= strb_s1_d;
            strb_s2_q <= strb_s2_d;
        end
    end

    always_ff @(posedge clk) begin
        ins_s1_q <= ins_s1_d;
        ins_s2_q <= ins_s2_d;
    end

    assign strb_sync = strb_s2_q;
    assign ins_sync  = ins_s2_q;
`else
    logic       strb_s1_q, strb_s1_d;
    logic [4:0] ins_s1_q, ins_s1_d;

    always_comb begin
        strb_s1_d = cmd[5];
        ins_s1_d  = cmd[4:0];
    end

    always_ff @(posedge clk) begin
        if (rst) strb_s1_q <= 1'b1;
        else     strb_s1_q <= strb_s1_d;
    end

    always_ff @(posedge clk) begin
        ins_s1_q <= ins_s1_d;
    end

    assign strb_sync = strb_s1_q;
    assign ins_sync  = ins_s1_q;
`endif

    logic exec;
    assign prev_d = strb_sync;
    assign exec   = strb_sync & ~prev_q;

    logic [3:0]     mem_q [DEPTH];
    logic [3:0]     mem_d [DEPTH];
    logic [SPW-1:0] sp_q, sp_d;
    logic           err_q, err_d;
    logic           carry_q, carry_d;

    logic [SPW-1:0] tos_idx, nos_idx;
    logic [3:0]     tos_v, nos_v;
    logic [4:0]     arith;

    assign tos_idx = sp_q - SP_ONE;
    assign nos_idx = sp_q - SP_TWO;
    assign tos_v   = mem_q[tos_idx[AW-1:0]];
    assign nos_v   = mem_q[nos_idx[AW-1:0]];

    always_comb begin
        sp_d    = sp_q;
        err_d   = err_q;
        carry_d = carry_q;
        mem_d   = mem_q;
        arith   = 5'd0;
        if (exec) begin
            if (ins_sync[4]) begin
                if (sp_q == SP_FULL) err_d = 1'b1;
                else begin
                    mem_d[sp_q[AW-1:0]] = ins_sync[3:0];
                    sp_d = sp_q + SP_ONE;
                end
            end else if (!ins_sync[3]) begin
                case (op_e'(ins_sync[2:0]))
                    OP_POP: begin
                        if (sp_q < SP_ONE) err_d = 1'b1;
                        else sp_d = tos_idx;
                    end
                    OP_ADD, OP_SUB: begin
                        if (sp_q < SP_TWO) err_d = 1'b1;
                        else begin
                            arith = (ins_sync[0]) ? sub_b(nos_v, tos_v) : add_c(nos_v, tos_v);
                            mem_d[nos_idx[AW-1:0]] = arith[3:0];
                            carry_d = arith[4];
                            sp_d = tos_idx;
                        end
                    end
                    OP_DUP: begin
                        if (sp_q < SP_ONE || sp_q == SP_FULL) err_d = 1'b1;
                        else begin
                            mem_d[sp_q[AW-1:0]] = tos_v;
                            sp_d = sp_q + SP_ONE;
                        end
                    end
                    OP_SWAP: begin
                        if (sp_q < SP_TWO) err_d = 1'b1;
                        else begin
                            mem_d[tos_idx[AW-1:0]] = nos_v;
                            mem_d[nos_idx[AW-1:0]] = tos_v;
                        end
                    end
                    OP_NOT: begin
                        if (sp_q < SP_ONE) err_d = 1'b1;
                        else mem_d[tos_idx[AW-1:0]] = ~tos_v;
                    end
                    OP_CLR: begin
                        sp_d    = '0;
                        err_d   = 1'b0;
                        carry_d = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= 1'b1;
            sp_q    <= '0;
            err_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
            carry_q <= carry_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    logic empty, full;
    assign empty = (sp_q == '0);
    assign full  = (sp_q == SP_FULL);
    assign out   = {err_q, carry_q, full, empty, (empty ? 4'h0 : tos_v)};

endmodule

// File: tb/tb_stackcalc_exec.sv
// Directed plus randomized bench for stackcalc_exec against a queue-based stack model.
module tb_stackcalc_exec;

    localparam int DEPTH = 8;
`ifdef STACKCALC_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] cmd = 6'h00;
    logic [7:0] dout;

    stackcalc_exec #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .cmd(cmd),
        .out(dout)
    );

    always #5 clk = ~clk;

    int stk[$];
    bit m_err   = 1'b0;
    bit m_carry = 1'b0;
    int total   = 0;
    int passed  = 0;
    int failed  = 0;

    function automatic logic [7:0] exp_out();
        logic [3:0] t;
        t = (stk.size() == 0) ? 4'h0 : 4'(stk[stk.size()-1]);
        return {m_err, m_carry, (stk.size() == DEPTH), (stk.size() == 0), t};
    endfunction

    task automatic model_apply(input logic [4:0] ins);
        int a, b, r;
        if (ins[4]) begin
            if (stk.size() == DEPTH) m_err = 1'b1;
            else stk.push_back(int'(ins[3:0]));
        end else if (ins[3] == 1'b0) begin
            case (ins[2:0])
                3'd1: if (stk.size() < 1) m_err = 1'b1; else a = stk.pop_back();
                3'd2, 3'd3: begin
                    if (stk.size() < 2) m_err = 1'b1;
                    else begin
                        a = stk.pop_back();
                        b = stk.pop_back();
                        r = (ins[2:0] == 3'd2) ? b + a : b - a;
                        m_carry = (ins[2:0] == 3'd2) ? (r > 15) : (r < 0);
                        stk.push_back((r + 16) % 16);
                    end
                end
                3'd4: begin
                    if (stk.size() < 1 || stk.size() == DEPTH) m_err = 1'b1;
                    else stk.push_back(stk[stk.size()-1]);
                end
                3'd5: begin
                    if (stk.size() < 2) m_err = 1'b1;
                    else begin
                        a = stk.pop_back();
                        b = stk.pop_back();
                        stk.push_back(a);
                        stk.push_back(b);
                    end
                end
                3'd6: if (stk.size() < 1) m_err = 1'b1; else begin
                    a = stk.pop_back();
                    stk.push_back(15 - a);
                end
                3'd7: begin
                    stk.delete();
                    m_err   = 1'b0;
                    m_carry = 1'b0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: out=%h expected %h", tag, obs, expv);
        end
    endtask

    // Checks both the cycle before the execute edge and the edge itself.
    task automatic do_op(input string tag, input logic [4:0] ins);
        logic [7:0] pre;
        @(posedge clk); #1 cmd = {1'b0, ins};
        @(posedge clk); #1 cmd = {1'b1, ins};
        pre = exp_out();
        repeat (LAT) @(posedge clk);
        #1 check({tag, "_early"}, dout, pre);
        @(posedge clk);
        model_apply(ins);
        #1 check(tag, dout, exp_out());
        cmd = {1'b0, ins};
        repeat (LAT + 1) @(posedge clk);
    endtask

    localparam logic [4:0] I_POP = 5'b00001, I_ADD = 5'b00010, I_SUB = 5'b00011,
                           I_DUP = 5'b00100, I_SWAP = 5'b00101, I_CLR = 5'b00111;

    function automatic logic [4:0] push(input int v);
        return {1'b1, 4'(v)};
    endfunction

    initial begin
        logic [4:0] ins;
        int r;

        cmd = {1'b1, push(5)};
        @(posedge clk); #1 check("reset", dout, 8'h10);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1 check("strobe_through_reset", dout, 8'h10);
        cmd = 6'h00;
        repeat (LAT + 2) @(posedge clk);

        do_op("push5", push(5));
        do_op("push3", push(3));
        check("push3_lit", dout, 8'h03);
        do_op("add", I_ADD);
        check("add_lit", dout, 8'h08);

        do_op("clr0", I_CLR);
        do_op("push9a", push(9));
        do_op("push9b", push(9));
        do_op("add_carry", I_ADD);
        check("add_carry_lit", dout, 8'h42);
        do_op("push3b", push(3));
        do_op("sub_borrow", I_SUB);
        check("sub_borrow_lit", dout, 8'h4F);

        do_op("clr1", I_CLR);
        for (int i = 1; i <= 8; i++) do_op("fill", push(i));
        check("full_lit", dout, 8'h28);
        do_op("overflow", push(9));
        check("overflow_lit", dout, 8'hA8);
        do_op("clr2", I_CLR);
        check("clr_lit", dout, 8'h10);

        do_op("pop_empty", I_POP);
        check("underflow_lit", dout, 8'h90);
        do_op("push7", push(7));
        do_op("swap_under", I_SWAP);
        check("swap_under_lit", dout, 8'h87);
        do_op("push1", push(1));
        do_op("swap", I_SWAP);
        do_op("pop_after_swap", I_POP);
        check("nos_after_swap", dout, 8'h81);
        do_op("push7b", push(7));
        do_op("dup", I_DUP);
        check("dup_lit", dout, 8'h87);

        @(posedge clk); #1 cmd = {1'b0, push(4)};
        @(posedge clk); #1 cmd = {1'b1, push(4)};
        repeat (50) @(posedge clk);
        model_apply(push(4));
        #1 check("held_strobe", dout, exp_out());
        cmd = {1'b0, push(4)};
        repeat (LAT + 2) @(posedge clk);

        @(posedge clk); #1 cmd = {1'b0, I_POP};
        @(posedge clk); #1 cmd = {1'b1, I_POP};
        repeat (LAT) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        stk.delete();
        m_err   = 1'b0;
        m_carry = 1'b0;
        #1 check("rst_before_exec", dout, 8'h10);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("rst_no_late_exec", dout, 8'h10);
        cmd = {1'b0, I_POP};
        repeat (LAT + 2) @(posedge clk);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (n % 15 == 14)  ins = I_CLR;
            else if (r < 4)    ins = push($urandom_range(0, 15));
            else if (r == 9)   ins = {2'b01, 3'($urandom_range(0, 7))};
            else               ins = {2'b00, 3'($urandom_range(0, 6))};
            do_op("rand", ins);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/stackcalc_exec.md
# stackcalc_exec

Execution stage of the stack calculator: it takes the operator command pins and keeps a small LIFO stack of 4-bit values. On each strobe edge it applies one stack operation. It drives the top-of-stack value and status flags onto the output pins. It sits directly downstream of the pin interface (clk = pin 0, rst = pin 1, cmd = pins 7:2) and feeds the output pin register.

## Interface
- `DEPTH`, default 8: number of stack entries (2..16).
- `clk`  input  1  clock.
- `rst`  input  1  reset, synchronous, active-high.
- `cmd`  input  6  operator command. `cmd[5]` is the strobe; `cmd[4:0]` is the instruction.
- `out`  output 8  status and data: {err, carry, full, empty, tos[3:0]}.

## Operation
- Instruction encoding, taken from the synchronized copy of `cmd[4:0]`:
  - `1dddd`: PUSH immediate `dddd`.
  - `00000`: NOP.
  - `00001`: POP.
  - `00010`: ADD, computes NOS+TOS.
  - `00011`: SUB, computes NOS−TOS.
  - `00100`: DUP.
  - `00101`: SWAP.
  - `00110`: NOT, inverts TOS.
  - `00111`: CLR.
  - `01xxx`: NOP.
- Stack state: `DEPTH`×4-bit storage plus a count register `sp` (0..DEPTH).
- Flag outputs:
  - empty = (sp==0).
  - full = (sp==DEPTH).
  - tos = top entry, or 0 when empty.
- Arithmetic (ADD, SUB) pops 2 and pushes 1, result mod 16.
  - carry ← carry-out for ADD, borrow for SUB.
  - carry is unchanged by every other operation.
- Error conditions:
  - Underflow: POP, NOT or DUP with sp<1; ADD, SUB or SWAP with sp<2.
  - Overflow: PUSH or DUP with sp==DEPTH.
- On error the operation has no effect on the stack and sets `err`. `err` is sticky.
- CLR: sp←0, err←0, carry←0. Stack contents are don't-care.
- Exactly one instruction executes per rising edge of the synchronized strobe. A held-high strobe executes only once.

## Timing
- Reset values: sp=0, err=0, carry=0. Therefore `out`=8'h10 (empty=1) at the first edge with rst high.
- Synchronizer and edge-detect registers reset to 1, so a strobe held high through reset does not execute. The strobe must go low, then high.
- Strobe path (with sync enabled):
  - `cmd` is captured in s1 at edge k and in s2 at edge k+1.
  - Execution happens at edge k+2, when s2=1 and prev=0.
  - `out` reflects the new state after edge k+2. Latency is 3 edges from the pin change.
- `cmd[4:0]` travels through the same sync stages as the strobe, so the instruction and strobe stay aligned. The operator must hold `cmd[4:0]` stable from one cycle before the strobe rises until the execute edge.
- `out` is combinational from the registered state only; it never depends on `cmd` directly.
- rst mid-operation: a pending edge is discarded and the state returns to reset values on that edge.
- An edge occurring while rst is high is lost.

## Configuration
- `STACKCALC_SYNC_EN` defined: two-flop synchronizer (s1, s2) before edge detect; latency 3 edges.
- `STACKCALC_SYNC_EN` undefined: one capture register only; execution at edge k+1; latency 2 edges.
- All functional behaviour is identical in both builds apart from latency.

## Test plan
- Reset → `out`=8'h10.
  - Hold strobe high through reset release → no execution; `out` stays 8'h10.
- PUSH 5, then PUSH 3 → `out`=8'h03, sp=2.
  - ADD → `out`=8'h08, carry=0, sp=1.
  - Check execution lands exactly on edge k+2 (k+1 without the macro).
- PUSH 9, PUSH 9, ADD → tos=2, carry=1 (`out`=8'h42).
  - Then PUSH 3, SUB → tos=15 (2−3), borrow=1 (`out`=8'h4F).
- Fill the stack with 8 PUSHes of 1..8 → full=1 (`out`=8'h28).
  - 9th PUSH → err=1, tos remains 8 (`out`=8'hA8).
  - CLR → `out`=8'h10.
- From empty: POP → err=1, `out`=8'h90.
  - Then PUSH 7, SWAP → err stays 1, tos=7.
  - PUSH 1, SWAP → tos=7, NOS=1.
  - DUP → tos=7, sp=3.
- Strobe held high for 50 cycles → exactly one execution.
  - Assert rst one cycle before the execute edge → no execution; `out`=8'h10.
